uart_dbg_loader: RTL and testbench
==================================

# uart_dbg_loader

Bus-initiating debug loader on the UART register port: enables the UART, polls its status/RX registers, assembles fixed-length download frames, and writes each word into memory while holding the CPU in reset. Sits between the UART register interface (initiator side) and a simple memory write port, so programs can be downloaded over the serial line without the core running.

## Interface
- UART_BASE, 32'h0000_0000 — base of UART registers; offsets CTRL 0x00, STATUS 0x04, TXDATA 0x0C, RXDATA 0x10 added to it.
- HDR_BYTE, 8'hA5 — frame start byte.
- ACK_BYTE, 8'h06 / NAK_BYTE, 8'h15 — response bytes.
- BYTE_TIMEOUT, 32'd5_000_000 — max clk cycles between bytes inside a frame.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- dbg_en_i  in  1  loader enable; low aborts to IDLE.
- uart_we_o  out  1  UART register write strobe.
- uart_waddr_o  out  32  UART write address.
- uart_wdata_o  out  32  UART write data.
- uart_re_o  out  1  UART register read strobe.
- uart_raddr_o  out  32  UART read address.
- uart_rdata_i  in  32  UART read data, valid the cycle after uart_re_o.
- mem_we_o  out  1  memory write request, held until accepted.
- mem_addr_o  out  32  memory word address.
- mem_wdata_o  out  32  memory write data.
- mem_ready_i  in  1  memory accepts write when high with mem_we_o.
- hold_cpu_o  out  1  CPU hold; high from INIT until END frame or abort.
- done_o  out  1  one-cycle pulse on END frame.
- err_o  out  1  one-cycle pulse on checksum fail, bad cmd or timeout.

## Operation
- Frame: HDR, CMD, ADDR[7:0..31:24], DATA[7:0..31:24], CSUM; 11 bytes, little-endian. CSUM = XOR of CMD, 4 addr bytes, 4 data bytes.
- CMD 0x01 WRITE: on good CSUM, mem write ADDR<=DATA, then ACK. CMD 0x02 END: good CSUM -> ACK, done_o, hold_cpu_o low, go IDLE. Other CMD or bad CSUM -> NAK, err_o, no mem write.
- States: IDLE, INIT, RX_POLL, RX_CHK, RX_RD, RX_CAP, RX_CLR, PARSE, MEM_WR, TX_POLL, TX_CHK, TX_WR.
- IDLE: all strobes low; dbg_en_i high -> INIT.
- INIT: one cycle write CTRL=0x3 (0x2 without ACK macro); hold_cpu_o set; -> RX_POLL.
- RX_POLL: read STATUS -> RX_CHK; bit1=0 -> RX_POLL, bit1=1 -> RX_RD.
- RX_RD: read RXDATA -> RX_CAP latches uart_rdata_i[7:0] -> RX_CLR writes STATUS=0 (clears rx-over) -> PARSE.
- PARSE: byte index 0 accepts only HDR_BYTE (other bytes dropped, index stays 0); indices 1..10 shift into CMD/ADDR/DATA/CSUM; after index 10 evaluate frame, index -> 0.
- MEM_WR: mem_we_o high with addr/data stable until cycle where mem_ready_i=1; drop next cycle -> TX_POLL.
- TX_POLL/TX_CHK: read STATUS, wait bit0=0; TX_WR writes TXDATA=response byte -> RX_POLL.
- Timeout counter: runs when byte index != 0, clears on every captured byte; reaching BYTE_TIMEOUT -> err_o, index 0, no response.
- dbg_en_i low in any state: next cycle IDLE, strobes low, hold_cpu_o low, index 0; pending mem write dropped.

## Timing
- Reset: all outputs 0, state IDLE, index 0, counter 0.
- Never uart_we_o and uart_re_o in same cycle; strobes are one-cycle pulses, addresses/data valid with strobe.
- Min per-byte RX overhead after rx-over: 5 cycles (POLL, CHK, RD, CAP, CLR).
- done_o/err_o coincide with the cycle the response byte is selected (PARSE exit).
- Mem write latency: mem_we_o asserted 1 cycle after PARSE of CSUM byte.

## Configuration
- UART_DBG_ACK_EN defined: ACK/NAK transmitted, CTRL=0x3, TX states present.
- Undefined: CTRL=0x2, TX states removed, PARSE/MEM_WR go directly to RX_POLL; done_o/err_o unchanged.

## Test plan
- Frame A5 01 00 10 00 00 EF BE AD DE ^csum -> mem_we_o addr 0x00001000 data 0xDEADBEEF held through 3-cycle mem_ready_i delay; TXDATA write 0x06.
- Same frame with CSUM^0x01 -> no mem_we_o, err_o pulse, TXDATA 0x15.
- Bytes 0x00 0x55 then valid frame -> garbage ignored, frame written correctly.
- 5 bytes then silence (BYTE_TIMEOUT=100) -> err_o at 100 cycles, next valid frame accepted.
- END frame A5 02 ×8 zeros 02 -> ACK, done_o pulse, hold_cpu_o 1->0, state IDLE.
- dbg_en_i low during MEM_WR -> mem_we_o low next cycle, hold_cpu_o 0; reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_dbg_loader.sv
// uart_dbg_loader
//
// Debug download engine that drives the UART register port as a bus
// initiator. It enables the UART, polls for received bytes, assembles
// 11-byte download frames (HDR, CMD, ADDR[4], DATA[4], CSUM, little-endian)
// and writes each WRITE frame's word into memory while the CPU is held in
// reset. An END frame releases the CPU and returns the loader to IDLE.
//
// Optional feature macro: UART_DBG_ACK_EN
//   defined   : ACK/NAK byte sent back after each frame, UART CTRL = 0x3
//   undefined : no transmit path, UART CTRL = 0x2
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   dbg_en_i            loader enable; dropping it aborts to IDLE
//   uart_we_o/waddr/wdata   UART register write strobe, address, data
//   uart_re_o/raddr         UART register read strobe, address
//   uart_rdata_i            UART read data, valid the cycle after uart_re_o
//   mem_we_o/addr/wdata     memory write request, held until mem_ready_i
//   mem_ready_i             memory accepts the write this cycle
//   hold_cpu_o              CPU held in reset while downloading
//   done_o                  one-cycle pulse on a good END frame
//   err_o                   one-cycle pulse on bad checksum/command/timeout
module uart_dbg_loader #(
    parameter logic [31:0] UART_BASE    = 32'h0000_0000,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15,
    parameter logic [31:0] BYTE_TIMEOUT = 32'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_en_i,
    output logic        uart_we_o,
    output logic [31:0] uart_waddr_o,
    output logic [31:0] uart_wdata_o,
    output logic        uart_re_o,
    output logic [31:0] uart_raddr_o,
    input  logic [31:0] uart_rdata_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    output logic        hold_cpu_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [31:0] OFS_CTRL   = 32'h00;
    localparam logic [31:0] OFS_STATUS = 32'h04;
    localparam logic [31:0] OFS_TXDATA = 32'h0C;
    localparam logic [31:0] OFS_RXDATA = 32'h10;
    localparam logic [7:0]  CMD_WRITE  = 8'h01;
    localparam logic [7:0]  CMD_END    = 8'h02;
`ifdef UART_DBG_ACK_EN
    localparam logic [31:0] CTRL_VAL   = 32'h3;
`else
    localparam logic [31:0] CTRL_VAL   = 32'h2;
`endif

    typedef enum logic [3:0] {
        IDLE, INIT, RX_POLL, RX_CHK, RX_RD, RX_CAP, RX_CLR, PARSE, MEM_WR
`ifdef UART_DBG_ACK_EN
        , TX_POLL, TX_CHK, TX_WR
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx;
    logic [7:0]  rx_byte;
    logic [7:0]  cmd;
    logic [7:0]  csum_acc;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] tmo_cnt;
    logic        hold_q;
    logic        armed;
    logic        frame_eval;
    logic        csum_ok;
    logic        frame_good;
    logic        tmo_hit;
`ifdef UART_DBG_ACK_EN
    logic [7:0]  resp_q;
    logic        end_pend;
`endif

    // Frame evaluation happens in the PARSE visit of the checksum byte (idx 10).
    assign frame_eval = (state == PARSE) && (idx == 4'd10);
    assign csum_ok    = (csum_acc == rx_byte);
    assign frame_good = csum_ok && ((cmd == CMD_WRITE) || (cmd == CMD_END));
    assign tmo_hit    = (idx != 4'd0) && (tmo_cnt >= BYTE_TIMEOUT);

    assign done_o      = dbg_en_i && frame_eval && csum_ok && (cmd == CMD_END);
    assign err_o       = dbg_en_i && ((frame_eval && !frame_good) || tmo_hit);
    assign hold_cpu_o  = hold_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = data_q;

    // Next-state and bus strobes. Strobes are decoded from the current state
    // only, so each UART access is a single-cycle pulse and reads and writes
    // can never overlap.
    always_comb begin
        state_nxt    = state;
        uart_we_o    = 1'b0;
        uart_waddr_o = '0;
        uart_wdata_o = '0;
        uart_re_o    = 1'b0;
        uart_raddr_o = '0;
        mem_we_o     = 1'b0;
        case (state)
            IDLE:    if (armed) state_nxt = INIT;
            INIT: begin
                uart_we_o    = 1'b1;
                uart_waddr_o = UART_BASE + OFS_CTRL;
                uart_wdata_o = CTRL_VAL;
                state_nxt    = RX_POLL;
            end
            RX_POLL: begin
                uart_re_o    = 1'b1;
                uart_raddr_o = UART_BASE + OFS_STATUS;
                state_nxt    = RX_CHK;
            end
            RX_CHK:  state_nxt = uart_rdata_i[1] ? RX_RD : RX_POLL;
            RX_RD: begin
                uart_re_o    = 1'b1;
                uart_raddr_o = UART_BASE + OFS_RXDATA;
                state_nxt    = RX_CAP;
            end
            RX_CAP:  state_nxt = RX_CLR;
            RX_CLR: begin
                uart_we_o    = 1'b1;
                uart_waddr_o = UART_BASE + OFS_STATUS;
                state_nxt    = PARSE;
            end
            PARSE: begin
                state_nxt = RX_POLL;
                if (frame_eval) begin
                    if (csum_ok && (cmd == CMD_WRITE)) state_nxt = MEM_WR;
`ifdef UART_DBG_ACK_EN
                    else                               state_nxt = TX_POLL;
`else
                    else if (done_o)                   state_nxt = IDLE;
`endif
                end
            end
            MEM_WR: begin
                mem_we_o = 1'b1;
`ifdef UART_DBG_ACK_EN
                if (mem_ready_i) state_nxt = TX_POLL;
`else
                if (mem_ready_i) state_nxt = RX_POLL;
`endif
            end
`ifdef UART_DBG_ACK_EN
            TX_POLL: begin
                uart_re_o    = 1'b1;
                uart_raddr_o = UART_BASE + OFS_STATUS;
                state_nxt    = TX_CHK;
            end
            TX_CHK:  state_nxt = uart_rdata_i[0] ? TX_POLL : TX_WR;
            TX_WR: begin
                uart_we_o    = 1'b1;
                uart_waddr_o = UART_BASE + OFS_TXDATA;
                uart_wdata_o = {24'd0, resp_q};
                state_nxt    = end_pend ? IDLE : RX_POLL;
            end
`endif
            default: state_nxt = IDLE;
        endcase
        if (!dbg_en_i) state_nxt = IDLE;
    end

    // State, frame assembly and timeout. 'armed' stops the loader from
    // immediately re-grabbing the CPU after an END frame while dbg_en_i is
    // still high; the host must drop dbg_en_i once before another session.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= 4'd0;
            rx_byte  <= 8'd0;
            cmd      <= 8'd0;
            csum_acc <= 8'd0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            tmo_cnt  <= 32'd0;
            hold_q   <= 1'b0;
            armed    <= 1'b1;
`ifdef UART_DBG_ACK_EN
            resp_q   <= 8'd0;
            end_pend <= 1'b0;
`endif
        end else if (!dbg_en_i) begin
            state    <= IDLE;
            idx      <= 4'd0;
            tmo_cnt  <= 32'd0;
            hold_q   <= 1'b0;
            armed    <= 1'b1;
`ifdef UART_DBG_ACK_EN
            end_pend <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == INIT) hold_q <= 1'b1;
            if (done_o) begin
                hold_q <= 1'b0;
                armed  <= 1'b0;
            end
            if (state == RX_CAP) begin
                rx_byte <= uart_rdata_i[7:0];
                tmo_cnt <= 32'd0;
            end else if (tmo_hit) begin
                tmo_cnt <= 32'd0;
                idx     <= 4'd0;
            end else if (idx != 4'd0) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            // Address and data arrive LSB first, so each byte is shifted in
            // from the top of its word.
            if (state == PARSE) begin
                if (idx == 4'd0) begin
                    if (rx_byte == HDR_BYTE) begin
                        idx      <= 4'd1;
                        csum_acc <= 8'd0;
                    end
                end else if (idx == 4'd10) begin
                    idx <= 4'd0;
`ifdef UART_DBG_ACK_EN
                    resp_q   <= frame_good ? ACK_BYTE : NAK_BYTE;
                    end_pend <= done_o;
`endif
                end else begin
                    idx      <= idx + 4'd1;
                    csum_acc <= csum_acc ^ rx_byte;
                    if (idx == 4'd1)      cmd    <= rx_byte;
                    else if (idx <= 4'd5) addr_q <= {rx_byte, addr_q[31:8]};
                    else                  data_q <= {rx_byte, data_q[31:8]};
                end
            end
        end
    end

    // Upper read-data bits carry nothing the loader needs.
    logic unused_ok;
`ifdef UART_DBG_ACK_EN
    assign unused_ok = &{1'b0, uart_rdata_i[31:8]};
`else
    assign unused_ok = &{1'b0, uart_rdata_i[31:8], ACK_BYTE, NAK_BYTE};
`endif

endmodule

// File: tb/tb_uart_dbg_loader.sv
// Self-checking bench for uart_dbg_loader. A behavioural UART (byte queue,
// rx-available and tx-busy status bits) and a memory with programmable
// ready delay surround the DUT. Stimulus pushes expected events into a
// scoreboard queue; a monitor pops and compares on every DUT event.
`timescale 1ns/1ps
module tb_uart_dbg_loader;

    localparam int EV_CTRL = 0;
    localparam int EV_TX   = 1;
    localparam int EV_MEM  = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;
`ifdef UART_DBG_ACK_EN
    localparam logic [31:0] CTRL_EXP = 32'h3;
`else
    localparam logic [31:0] CTRL_EXP = 32'h2;
`endif

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_en;
    logic        uart_we_o;
    logic [31:0] uart_waddr_o;
    logic [31:0] uart_wdata_o;
    logic        uart_re_o;
    logic [31:0] uart_raddr_o;
    logic [31:0] uart_rdata_i = 32'd0;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i = 1'b0;
    logic        hold_cpu_o;
    logic        done_o;
    logic        err_o;

    ev_t        sb[$];
    logic [7:0] rx_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int err_cyc = 0;
    int tx_busy = 0;
    int mem_cnt = 0;
    int mem_delay = 3;

    uart_dbg_loader #(.BYTE_TIMEOUT(32'd100)) dut (
        .clk          (clk),
        .rst          (rst),
        .dbg_en_i     (dbg_en),
        .uart_we_o    (uart_we_o),
        .uart_waddr_o (uart_waddr_o),
        .uart_wdata_o (uart_wdata_o),
        .uart_re_o    (uart_re_o),
        .uart_raddr_o (uart_raddr_o),
        .uart_rdata_i (uart_rdata_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .hold_cpu_o   (hold_cpu_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expectEv(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        sb.push_back(e);
    endtask

    task automatic scoreCheck(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL sb_unexpected: got kind=%0d a=%h d=%h, required no event", kind, a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.a !== a || e.d !== d) begin
                fails++;
                $display("[TB] FAIL sb_event: got kind=%0d a=%h d=%h, required kind=%0d a=%h d=%h",
                         kind, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    // Queue n bytes for the UART model; first byte is the most significant in v.
    task automatic applyStimulus(input logic [87:0] v, input int n);
        for (int i = 0; i < n; i++) rx_q.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 3000 && (sb.size() != 0 || rx_q.size() != 0); i++) @(negedge clk);
        tests++;
        if (sb.size() != 0 || rx_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_drain: got %0d events %0d bytes pending, required 0 and 0",
                     name, sb.size(), rx_q.size());
        end
        repeat (10) @(negedge clk);
    endtask

    // Monitor first (sees this cycle's DUT outputs), then the UART/memory
    // models update the inputs the DUT samples at the next rising edge.
    always @(negedge clk) begin
        if (uart_we_o || uart_re_o) begin
            tests++;
            if (uart_we_o && uart_re_o) begin
                fails++;
                $display("[TB] FAIL strobe_excl: got we=1 re=1, required at most one");
            end
        end
        if (uart_we_o) begin
            if (uart_waddr_o == 32'h04) begin
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                last_pop_cyc = cyc;
            end else if (uart_waddr_o == 32'h0C) begin
                scoreCheck(EV_TX, uart_waddr_o, uart_wdata_o);
            end else begin
                scoreCheck(EV_CTRL, uart_waddr_o, uart_wdata_o);
            end
        end
        if (done_o) begin
            checkOutput("hold_at_done", {31'd0, hold_cpu_o}, 32'd1);
            scoreCheck(EV_DONE, 32'd0, 32'd0);
        end
        if (err_o) begin
            err_cyc = cyc;
            scoreCheck(EV_ERR, 32'd0, 32'd0);
        end
        if (uart_re_o) begin
            if (uart_raddr_o == 32'h04)
                uart_rdata_i = {30'd0, rx_q.size() > 0, tx_busy > 0};
            else if (uart_raddr_o == 32'h10)
                uart_rdata_i = (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'd0;
            else
                uart_rdata_i = 32'hFFFF_FFFF;
        end
        if (tx_busy > 0) tx_busy--;
        if (uart_we_o && uart_waddr_o == 32'h0C) tx_busy = 3;
        if (mem_we_o) begin
            mem_cnt++;
            mem_ready_i = (mem_cnt > mem_delay);
            if (mem_ready_i) scoreCheck(EV_MEM, mem_addr_o, mem_wdata_o);
        end else begin
            mem_cnt = 0;
            mem_ready_i = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int delta;
        rst    = 1'b0;
        dbg_en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_uart_we", {31'd0, uart_we_o}, 32'd0);
        checkOutput("rst_uart_re", {31'd0, uart_re_o}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        checkOutput("rst_hold", {31'd0, hold_cpu_o}, 32'd0);
        checkOutput("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_disabled_re", {31'd0, uart_re_o}, 32'd0);

        // Enable: CTRL write, CPU held
        expectEv(EV_CTRL, 32'h0, CTRL_EXP);
        dbg_en = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("hold_after_init", {31'd0, hold_cpu_o}, 32'd1);

        // Good WRITE frame, memory ready after 3 wait cycles
        expectEv(EV_MEM, 32'h0000_1000, 32'hDEAD_BEEF);
`ifdef UART_DBG_ACK_EN
        expectEv(EV_TX, 32'h0C, 32'h06);
`endif
        applyStimulus(88'hA5_01_00_10_00_00_EF_BE_AD_DE_33, 11);
        waitDrain("write_good");

        // Corrupted checksum: error, no memory write
        expectEv(EV_ERR, 32'd0, 32'd0);
`ifdef UART_DBG_ACK_EN
        expectEv(EV_TX, 32'h0C, 32'h15);
`endif
        applyStimulus(88'hA5_01_00_10_00_00_EF_BE_AD_DE_32, 11);
        waitDrain("bad_csum");

        // Garbage before header is ignored
        expectEv(EV_MEM, 32'h0000_0004, 32'h1234_5678);
`ifdef UART_DBG_ACK_EN
        expectEv(EV_TX, 32'h0C, 32'h06);
`endif
        applyStimulus(88'h00_55, 2);
        applyStimulus(88'hA5_01_04_00_00_00_78_56_34_12_0D, 11);
        waitDrain("garbage_then_frame");

        // Partial frame then silence: timeout error, no response
        expectEv(EV_ERR, 32'd0, 32'd0);
        applyStimulus(88'hA5_01_00_10_00, 5);
        waitDrain("timeout");
        delta = err_cyc - last_pop_cyc;
        tests++;
        if (delta < 98 || delta > 106) begin
            fails++;
            $display("[TB] FAIL timeout_latency: got %0d cycles, required about 100", delta);
        end

        // Frame after timeout is accepted
        expectEv(EV_MEM, 32'h0000_1000, 32'hDEAD_BEEF);
`ifdef UART_DBG_ACK_EN
        expectEv(EV_TX, 32'h0C, 32'h06);
`endif
        applyStimulus(88'hA5_01_00_10_00_00_EF_BE_AD_DE_33, 11);
        waitDrain("after_timeout");

        // END frame: done pulse, CPU released, loader stays idle
        expectEv(EV_DONE, 32'd0, 32'd0);
`ifdef UART_DBG_ACK_EN
        expectEv(EV_TX, 32'h0C, 32'h06);
`endif
        applyStimulus(88'hA5_02_00_00_00_00_00_00_00_00_02, 11);
        waitDrain("end_frame");
        checkOutput("hold_after_end", {31'd0, hold_cpu_o}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("end_stays_idle_hold", {31'd0, hold_cpu_o}, 32'd0);
        checkOutput("end_stays_idle_re", {31'd0, uart_re_o}, 32'd0);
        dbg_en = 1'b0;
        repeat (2) @(negedge clk);

        // Abort during a stalled memory write
        expectEv(EV_CTRL, 32'h0, CTRL_EXP);
        dbg_en    = 1'b1;
        mem_delay = 50;
        applyStimulus(88'hA5_01_00_10_00_00_EF_BE_AD_DE_33, 11);
        for (int i = 0; i < 500 && !mem_we_o; i++) @(negedge clk);
        checkOutput("abort_mem_we_seen", {31'd0, mem_we_o}, 32'd1);
        dbg_en = 1'b0;
        @(negedge clk);
        checkOutput("abort_mem_we_drop", {31'd0, mem_we_o}, 32'd0);
        checkOutput("abort_hold", {31'd0, hold_cpu_o}, 32'd0);
        mem_delay = 3;
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame
        expectEv(EV_CTRL, 32'h0, CTRL_EXP);
        dbg_en = 1'b1;
        applyStimulus(88'hA5_01_00_10, 4);
        for (int i = 0; i < 500 && rx_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_uart_we", {31'd0, uart_we_o}, 32'd0);
        checkOutput("midrst_uart_re", {31'd0, uart_re_o}, 32'd0);
        checkOutput("midrst_mem_we", {31'd0, mem_we_o}, 32'd0);
        checkOutput("midrst_hold", {31'd0, hold_cpu_o}, 32'd0);
        checkOutput("midrst_done_err", {30'd0, done_o, err_o}, 32'd0);
        rx_q.delete();
        dbg_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
